// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: RX line, checker results and sequencer strobes for the UART RX path.
interface uart_rx_fsm_if;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] PRESCALE;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    modport master (
        input  RX_IN, PAR_EN, PRESCALE, strt_glitch, par_err, stp_err,
        output dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid
    );
    modport slave (
        output RX_IN, PAR_EN, PRESCALE, strt_glitch, par_err, stp_err,
        input  dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART RX sequencer; tracks bit/edge position and strobes the datapath checkers.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input logic          CLK,
    input logic          RST,
    uart_rx_fsm_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t     state, state_nx;
    logic [5:0] edge_q, edge_nx, p_reg, p_nx;
    logic [3:0] bit_q, bit_nx;
    logic       last_edge, at_mid;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            edge_q <= '0;
            bit_q  <= '0;
            p_reg  <= 6'd8;
        end else begin
            state  <= state_nx;
            edge_q <= edge_nx;
            bit_q  <= bit_nx;
            p_reg  <= p_nx;
        end
    end
    always_comb begin
        last_edge = edge_q == p_reg - 6'd1;
        state_nx  = state;
        edge_nx   = last_edge ? 6'd0 : edge_q + 6'd1;
        bit_nx    = bit_q;
        p_nx      = p_reg;
        case (state)
            IDLE: begin
                edge_nx  = bus.RX_IN ? 6'd0 : 6'd1;
                bit_nx   = '0;
                p_nx     = bus.RX_IN ? p_reg : bus.PRESCALE;
                state_nx = bus.RX_IN ? IDLE : START;
            end
            START: begin
                bit_nx   = '0;
                state_nx = !last_edge ? START : (bus.strt_glitch ? IDLE : DATA);
            end
            DATA: if (last_edge) begin
                bit_nx   = (bit_q == 4'(DATA_WIDTH - 1)) ? 4'd0 : bit_q + 4'd1;
                state_nx = (bit_q != 4'(DATA_WIDTH - 1)) ? DATA : (bus.PAR_EN ? PARITY : STOP);
            end
            PARITY: state_nx = last_edge ? STOP : PARITY;
            STOP:   state_nx = last_edge ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end
    // Sampler votes at M-1..M+1, so the majority bit is settled at edge M+2.
    always_comb begin
        at_mid          = edge_q == (p_reg >> 1) + 6'd2;
        bus.edge_cnt    = edge_q;
        bus.bit_cnt     = bit_q;
        bus.dat_samp_en = state != IDLE;
        bus.strt_chk_en = state == START && at_mid;
        bus.deser_en    = state == DATA && at_mid;
        bus.par_chk_en  = state == PARITY && at_mid;
        bus.stp_chk_en  = state == STOP && at_mid;
        bus.data_valid  = state == STOP && last_edge && !bus.stp_err && (!bus.PAR_EN || !bus.par_err);
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames against a frame-offset model of the RX sequencer.
module tb_uart_rx_fsm;
    localparam int DW = 8;
    logic CLK = 0;
    logic RST;
    uart_rx_fsm_if bus ();
    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, cyc = 0, tf = 0;
    logic chk_on = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model: a frame is just an offset from the detect cycle; bit = o/P, edge = o%P.
    logic m_busy = 0, m_par = 0;
    int m_o = 0, m_p = 8;
    always @(posedge CLK) begin
        if (RST) m_busy <= 0;
        else if (!m_busy) begin
            if (!bus.RX_IN) begin
                m_busy <= 1; m_o <= 1; m_p <= int'(bus.PRESCALE); m_par <= bus.PAR_EN;
            end
        end else if ((m_o == m_p - 1 && bus.strt_glitch) || m_o == (DW + 2 + int'(m_par)) * m_p - 1) m_busy <= 0;
        else m_o <= m_o + 1;
    end

    int n_dv, dv_cyc, n_deser, first_deser, last_deser, n_strt, n_par, par_cyc, n_stp, stp_cyc;
    task automatic clear_log();
        n_dv = 0; dv_cyc = -1; n_deser = 0; first_deser = -1; last_deser = -1;
        n_strt = 0; n_par = 0; par_cyc = -1; n_stp = 0; stp_cyc = -1;
    endtask

    always @(negedge CLK) if (chk_on) begin
        int e, b, nb, mm, x_edge, x_bit, x_samp, x_strt, x_des, x_par, x_stp, x_dv;
        {x_edge, x_bit, x_samp, x_strt, x_des, x_par, x_stp, x_dv} = '0;
        if (m_busy) begin
            nb = DW + 2 + int'(m_par);
            e = m_o % m_p; b = m_o / m_p; mm = m_p / 2 + 2;
            x_samp = 1; x_edge = e;
            x_bit  = (b >= 1 && b <= DW) ? b - 1 : 0;
            x_strt = int'(b == 0 && e == mm);
            x_des  = int'(b >= 1 && b <= DW && e == mm);
            x_par  = int'(m_par && b == DW + 1 && e == mm);
            x_stp  = int'(b == nb - 1 && e == mm);
            x_dv   = int'(b == nb - 1 && e == m_p - 1 && !bus.stp_err && (!m_par || !bus.par_err));
        end
        chk("edge_cnt", int'(bus.edge_cnt), x_edge);
        chk("bit_cnt", int'(bus.bit_cnt), x_bit);
        chk("dat_samp_en", int'(bus.dat_samp_en), x_samp);
        chk("strt_chk_en", int'(bus.strt_chk_en), x_strt);
        chk("deser_en", int'(bus.deser_en), x_des);
        chk("par_chk_en", int'(bus.par_chk_en), x_par);
        chk("stp_chk_en", int'(bus.stp_chk_en), x_stp);
        chk("data_valid", int'(bus.data_valid), x_dv);
        if (bus.data_valid) begin n_dv++; dv_cyc = cyc; end
        if (bus.deser_en) begin n_deser++; last_deser = cyc; if (first_deser < 0) first_deser = cyc; end
        if (bus.strt_chk_en) n_strt++;
        if (bus.par_chk_en) begin n_par++; par_cyc = cyc; end
        if (bus.stp_chk_en) begin n_stp++; stp_cyc = cyc; end
    end

    task automatic send_frame(input int p, input logic par, input logic [7:0] d, input int p_after);
        logic [10:0] bits;
        int nb;
        bits = par ? {1'b1, ^d, d, 1'b0} : {1'b1, 1'b1, d, 1'b0};
        nb = par ? 11 : 10;
        @(posedge CLK); #1;
        tf = cyc; bus.PRESCALE = 6'(p); bus.PAR_EN = par;
        for (int i = 0; i < nb; i++) begin
            bus.RX_IN = (i == nb - 1) ? 1'b1 : bits[i];
            repeat (p) begin @(posedge CLK); #1; end
            if (i == 0) bus.PRESCALE = 6'(p_after);
        end
        bus.RX_IN = 1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge CLK); #1; end
    endtask

    int t0;
    initial begin
        clear_log();
        RST = 1; bus.RX_IN = 1; bus.PAR_EN = 0; bus.PRESCALE = 8;
        bus.strt_glitch = 0; bus.par_err = 0; bus.stp_err = 0;
        repeat (3) @(posedge CLK); #1;
        chk("rst_edge_cnt", int'(bus.edge_cnt), 0);
        chk("rst_bit_cnt", int'(bus.bit_cnt), 0);
        chk("rst_samp", int'(bus.dat_samp_en), 0);
        chk("rst_dv", int'(bus.data_valid), 0);
        RST = 0; chk_on = 1;

        clear_log(); send_frame(8, 0, 8'hA5, 8);
        chk("t1_n_deser", n_deser, 8);
        chk("t1_first_deser", first_deser - tf, 14);
        chk("t1_last_deser", last_deser - tf, 70);
        chk("t1_n_dv", n_dv, 1);
        chk("t1_dv_cyc", dv_cyc - tf, 79);

        clear_log(); send_frame(16, 1, 8'h3C, 16);
        chk("t2_n_strt", n_strt, 1);
        chk("t2_n_deser", n_deser, 8);
        chk("t2_n_par", n_par, 1);
        chk("t2_par_cyc", par_cyc - tf, 154);
        chk("t2_stp_cyc", stp_cyc - tf, 170);
        chk("t2_dv_cyc", dv_cyc - tf, 175);

        clear_log();
        @(posedge CLK); #1; t0 = cyc; bus.PRESCALE = 8; bus.PAR_EN = 0; bus.RX_IN = 0;
        @(posedge CLK); #1; bus.RX_IN = 1; bus.strt_glitch = 1;
        wait_until(t0 + 7);
        chk("t3_busy_at_7", int'(bus.dat_samp_en), 1);
        wait_until(t0 + 8);
        chk("t3_idle_at_8", int'(bus.dat_samp_en), 0);
        wait_until(t0 + 90);
        bus.strt_glitch = 0;
        chk("t3_n_deser", n_deser, 0);
        chk("t3_n_dv", n_dv, 0);

        bus.stp_err = 1; clear_log(); send_frame(8, 1, 8'h0F, 8);
        chk("t4_stp_err_dv", n_dv, 0);
        bus.stp_err = 0; bus.par_err = 1; clear_log(); send_frame(8, 1, 8'hF0, 8);
        chk("t4_par_err_dv", n_dv, 0);
        bus.par_err = 0; clear_log(); send_frame(8, 1, 8'h81, 8);
        chk("t4_clean_n_dv", n_dv, 1);
        chk("t4_clean_dv_cyc", dv_cyc - tf, 87);

        @(posedge CLK); #1; t0 = cyc; bus.PRESCALE = 32; bus.PAR_EN = 0; bus.RX_IN = 0;
        @(posedge CLK); #1; bus.RX_IN = 1;
        wait_until(t0 + 100);
        RST = 1;
        @(posedge CLK); #1; RST = 0;
        chk("t5_rst_samp", int'(bus.dat_samp_en), 0);
        chk("t5_rst_edge", int'(bus.edge_cnt), 0);
        chk("t5_rst_bit", int'(bus.bit_cnt), 0);
        chk("t5_rst_deser", int'(bus.deser_en), 0);
        wait_until(t0 + 109);
        clear_log(); send_frame(32, 0, 8'h5A, 32);
        chk("t5_start", tf - t0, 110);
        chk("t5_dv_cyc", dv_cyc - t0, 429);

        clear_log(); send_frame(8, 0, 8'h33, 16);
        chk("t6_dv_p8", dv_cyc - tf, 79);
        clear_log(); send_frame(16, 0, 8'hCC, 16);
        chk("t6_dv_p16", dv_cyc - tf, 159);

        repeat (5) @(posedge CLK);
        #1 chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
